// File: rtl/video_pkg.sv
// Shared video timing defaults, pattern modes and palette for the test-pattern generator.
package video_pkg;

  localparam int unsigned H_ACTIVE_D = 640;
  localparam int unsigned H_FRONT_D  = 16;
  localparam int unsigned H_SYNC_D   = 96;
  localparam int unsigned H_TOTAL_D  = 800;
  localparam int unsigned V_ACTIVE_D = 480;
  localparam int unsigned V_FRONT_D  = 10;
  localparam int unsigned V_SYNC_D   = 2;
  localparam int unsigned V_TOTAL_D  = 525;
  localparam int unsigned BOX_D      = 64;

  localparam int unsigned XW    = 10;
  localparam int unsigned YW    = 10;
  localparam int unsigned BXW   = 10;
  localparam int unsigned BYW   = 9;
  localparam int unsigned BAR_W = 80;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] C_CYAN    = 24'h00FFFF;
  localparam logic [23:0] C_GREEN   = 24'h00FF00;
  localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] C_RED     = 24'hFF0000;
  localparam logic [23:0] C_BLUE    = 24'h0000FF;
  localparam logic [23:0] C_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = C_WHITE;
      3'd1:    bar_colour = C_YELLOW;
      3'd2:    bar_colour = C_CYAN;
      3'd3:    bar_colour = C_GREEN;
      3'd4:    bar_colour = C_MAGENTA;
      3'd5:    bar_colour = C_RED;
      3'd6:    bar_colour = C_BLUE;
      default: bar_colour = C_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_timing.sv
// Raster x/y counters with combinational active-video, sync and frame-start terms.
module video_timing
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_D,
  parameter int unsigned H_FRONT  = H_FRONT_D,
  parameter int unsigned H_SYNC   = H_SYNC_D,
  parameter int unsigned H_TOTAL  = H_TOTAL_D,
  parameter int unsigned V_ACTIVE = V_ACTIVE_D,
  parameter int unsigned V_FRONT  = V_FRONT_D,
  parameter int unsigned V_SYNC   = V_SYNC_D,
  parameter int unsigned V_TOTAL  = V_TOTAL_D
) (
  input  logic          i_pxl_clk,
  input  logic          i_rst,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_de_c,
  output logic          o_hsync_c,
  output logic          o_vsync_c,
  output logic          o_frame_start_c
);

  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FRONT);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FRONT);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  always_ff @(posedge i_pxl_clk) begin
    if (!i_rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (r_x == X_LAST) begin
      r_x <= '0;
      r_y <= (r_y == Y_LAST) ? '0 : r_y + YW'(1);
    end else begin
      r_x <= r_x + XW'(1);
    end
  end

  // vsync depends on y only, so its edges fall on x=0.
  assign o_x             = r_x;
  assign o_y             = r_y;
  assign o_de_c          = (r_x < XW'(H_ACTIVE)) && (r_y < YW'(V_ACTIVE));
  assign o_hsync_c       = !((r_x >= HS_START) && (r_x < HS_END));
  assign o_vsync_c       = !((r_y >= VS_START) && (r_y < VS_END));
  assign o_frame_start_c = (r_x == '0) && (r_y == '0);

endmodule

// File: rtl/pattern_gen.sv
// Test-pattern generator: solid, colour bars, checkerboard and a bouncing box, one cycle behind the raster counters.
module pattern_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_D,
  parameter int unsigned H_FRONT  = H_FRONT_D,
  parameter int unsigned H_SYNC   = H_SYNC_D,
  parameter int unsigned H_TOTAL  = H_TOTAL_D,
  parameter int unsigned V_ACTIVE = V_ACTIVE_D,
  parameter int unsigned V_FRONT  = V_FRONT_D,
  parameter int unsigned V_SYNC   = V_SYNC_D,
  parameter int unsigned V_TOTAL  = V_TOTAL_D,
  parameter int unsigned BOX      = BOX_D
) (
  input  logic        pxl_clk,
  input  logic        rst,
  input  logic [1:0]  mode_i,
  input  logic [23:0] solid_rgb_i,
  output logic [7:0]  r_o,
  output logic [7:0]  g_o,
  output logic [7:0]  b_o,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        frame_start_o
);

  localparam logic [BXW-1:0] BX_MAX = BXW'(H_ACTIVE - BOX);
  localparam logic [BYW-1:0] BY_MAX = BYW'(V_ACTIVE - BOX);

  logic [XW-1:0]  w_x;
  logic [YW-1:0]  w_y;
  logic           w_de, w_hs, w_vs, w_fs;

  mode_e          r_mode;
  rgb_t           r_solid;
  logic [BXW-1:0] r_bx;
  logic [BYW-1:0] r_by;
  logic           r_dx, r_dy;
  rgb_t           r_out;
  logic           r_de, r_hs, r_vs, r_fs;

  logic [BXW-1:0] w_bx_nxt, w_bx;
  logic [BYW-1:0] w_by_nxt, w_by;
  logic           w_dx_nxt, w_dy_nxt;
  mode_e          w_mode;
  rgb_t           w_solid;
  logic           w_in_box;
  logic [2:0]     w_bar;
  rgb_t           w_pix;

  video_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_TOTAL(V_TOTAL)
  ) u_timing (
    .i_pxl_clk       (pxl_clk),
    .i_rst           (rst),
    .o_x             (w_x),
    .o_y             (w_y),
    .o_de_c          (w_de),
    .o_hsync_c       (w_hs),
    .o_vsync_c       (w_vs),
    .o_frame_start_c (w_fs)
  );

  // Per-axis bounce: at an edge the direction flips and the box steps back 1 px.
  always_comb begin
    w_bx_nxt = r_bx;
    w_dx_nxt = r_dx;
    w_by_nxt = r_by;
    w_dy_nxt = r_dy;
    if (r_dx) begin
      if (r_bx == BX_MAX) begin
        w_bx_nxt = r_bx - BXW'(1);
        w_dx_nxt = 1'b0;
      end else begin
        w_bx_nxt = r_bx + BXW'(1);
      end
    end else begin
      if (r_bx == '0) begin
        w_bx_nxt = BXW'(1);
        w_dx_nxt = 1'b1;
      end else begin
        w_bx_nxt = r_bx - BXW'(1);
      end
    end
    if (r_dy) begin
      if (r_by == BY_MAX) begin
        w_by_nxt = r_by - BYW'(1);
        w_dy_nxt = 1'b0;
      end else begin
        w_by_nxt = r_by + BYW'(1);
      end
    end else begin
      if (r_by == '0) begin
        w_by_nxt = BYW'(1);
        w_dy_nxt = 1'b1;
      end else begin
        w_by_nxt = r_by - BYW'(1);
      end
    end
  end

  // At (0,0) the freshly sampled frame state already applies to that first pixel.
  assign w_mode   = w_fs ? mode_e'(mode_i) : r_mode;
  assign w_solid  = w_fs ? rgb_t'(solid_rgb_i) : r_solid;
  assign w_bx     = w_fs ? w_bx_nxt : r_bx;
  assign w_by     = w_fs ? w_by_nxt : r_by;
  assign w_bar    = 3'(w_x / XW'(BAR_W));
  assign w_in_box = ((XW+1)'(w_x) >= (XW+1)'(w_bx)) &&
                    ((XW+1)'(w_x) <  (XW+1)'(w_bx) + (XW+1)'(BOX)) &&
                    ((YW+1)'(w_y) >= (YW+1)'(w_by)) &&
                    ((YW+1)'(w_y) <  (YW+1)'(w_by) + (YW+1)'(BOX));

  always_comb begin
    w_pix = rgb_t'(C_BLACK);
    case (w_mode)
      MODE_SOLID: w_pix = w_solid;
      MODE_BARS:  w_pix = rgb_t'(bar_colour(w_bar));
      MODE_CHECK: w_pix = (w_x[5] ^ w_y[5]) ? rgb_t'(C_BLACK) : rgb_t'(C_WHITE);
      default:    w_pix = w_in_box ? rgb_t'(C_WHITE) : rgb_t'(C_BLUE);
    endcase
  end

  always_ff @(posedge pxl_clk) begin
    if (!rst) begin
      r_mode  <= MODE_SOLID;
      r_solid <= '0;
      r_bx    <= '0;
      r_by    <= '0;
      r_dx    <= 1'b1;
      r_dy    <= 1'b1;
      r_out   <= '0;
      r_de    <= 1'b0;
      r_hs    <= 1'b1;
      r_vs    <= 1'b1;
      r_fs    <= 1'b0;
    end else begin
      r_de  <= w_de;
      r_hs  <= w_hs;
      r_vs  <= w_vs;
      r_fs  <= w_fs;
      r_out <= w_de ? w_pix : '0;
      if (w_fs) begin
        r_mode  <= mode_e'(mode_i);
        r_solid <= rgb_t'(solid_rgb_i);
        r_bx    <= w_bx_nxt;
        r_by    <= w_by_nxt;
        r_dx    <= w_dx_nxt;
        r_dy    <= w_dy_nxt;
      end
    end
  end

  assign r_o           = r_out.r;
  assign g_o           = r_out.g;
  assign b_o           = r_out.b;
  assign de_o          = r_de;
  assign hsync_o       = r_hs;
  assign vsync_o       = r_vs;
  assign frame_start_o = r_fs;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: three instances (full-width/short-frame, small, tiny) keep runtime short.
module tb_pattern_gen;

  logic pxl_clk = 1'b0;
  always #5 pxl_clk = ~pxl_clk;

  int checks = 0;
  int errors = 0;
  int pa, pb, pc;

  // A: full 800-px lines, 8-line frames (6400 cycles).
  logic       rst_a = 1'b0;
  logic [1:0] mode_a = 2'd0;
  logic [23:0] solid_a = 24'h0;
  logic [7:0] ra, ga, ba;
  logic de_a, hs_a, vs_a, fs_a;
  // B: 48x44 raster (2112 cycles), 32x32 checker cells fit.
  logic       rst_b = 1'b0;
  logic [1:0] mode_b = 2'd0;
  logic [23:0] solid_b = 24'h0;
  logic [7:0] rb, gb, bb;
  logic de_b, hs_b, vs_b, fs_b;
  // C: 16x13 raster (208 cycles), box 4, limits bx 8 / by 6.
  logic       rst_c = 1'b0;
  logic [1:0] mode_c = 2'd0;
  logic [23:0] solid_c = 24'h0;
  logic [7:0] rc, gc, bc;
  logic de_c, hs_c, vs_c, fs_c;

  pattern_gen #(.V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_TOTAL(8), .BOX(4)) u_a (
    .pxl_clk(pxl_clk), .rst(rst_a), .mode_i(mode_a), .solid_rgb_i(solid_a),
    .r_o(ra), .g_o(ga), .b_o(ba), .de_o(de_a), .hsync_o(hs_a), .vsync_o(vs_a),
    .frame_start_o(fs_a));

  pattern_gen #(.H_ACTIVE(40), .H_FRONT(2), .H_SYNC(4), .H_TOTAL(48),
                .V_ACTIVE(40), .V_FRONT(1), .V_SYNC(2), .V_TOTAL(44), .BOX(8)) u_b (
    .pxl_clk(pxl_clk), .rst(rst_b), .mode_i(mode_b), .solid_rgb_i(solid_b),
    .r_o(rb), .g_o(gb), .b_o(bb), .de_o(de_b), .hsync_o(hs_b), .vsync_o(vs_b),
    .frame_start_o(fs_b));

  pattern_gen #(.H_ACTIVE(12), .H_FRONT(1), .H_SYNC(2), .H_TOTAL(16),
                .V_ACTIVE(10), .V_FRONT(1), .V_SYNC(1), .V_TOTAL(13), .BOX(4)) u_c (
    .pxl_clk(pxl_clk), .rst(rst_c), .mode_i(mode_c), .solid_rgb_i(solid_c),
    .r_o(rc), .g_o(gc), .b_o(bc), .de_o(de_c), .hsync_o(hs_c), .vsync_o(vs_c),
    .frame_start_o(fs_c));

  task automatic tick();
    @(posedge pxl_clk);
    #1;
  endtask

  // p is the raster index of the pixel currently on the outputs.
  task automatic run_to(inout int p, input int t);
    while (p < t) begin
      tick();
      p++;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({de_a, hs_a, vs_a, fs_a, ra, ga, ba} !== {1'b0, 1'b1, 1'b1, 1'b0, 24'h0}) begin
      errors++;
      $display("FAIL reset_a: de/hs/vs/fs/rgb=%b%b%b%b %h required 0110 000000",
               de_a, hs_a, vs_a, fs_a, {ra, ga, ba});
    end
    checks++;
    if ({de_b, hs_b, vs_b, fs_b, rb, gb, bb} !== {1'b0, 1'b1, 1'b1, 1'b0, 24'h0}) begin
      errors++;
      $display("FAIL reset_b: de/hs/vs/fs/rgb=%b%b%b%b %h required 0110 000000",
               de_b, hs_b, vs_b, fs_b, {rb, gb, bb});
    end
    checks++;
    if ({de_c, hs_c, vs_c, fs_c, rc, gc, bc} !== {1'b0, 1'b1, 1'b1, 1'b0, 24'h0}) begin
      errors++;
      $display("FAIL reset_c: de/hs/vs/fs/rgb=%b%b%b%b %h required 0110 000000",
               de_c, hs_c, vs_c, fs_c, {rc, gc, bc});
    end
  endtask

  task automatic test_timing();
    int fs_cnt = 0, fs_last = -1, fs_bad = 0;
    int de_run = 0, de_runs = 0, de_bad = 0;
    int hs_run = 0, hs_pulses = 0, hs_bad = 0;
    int vs_low = 0, vs_fall = -1, vs_rise = -1;
    logic pde = 1'b0, phs = 1'b1, pvs = 1'b1;
    mode_a = 2'd1;
    rst_a  = 1'b1;
    pa = -1;
    for (int i = 0; i < 12800; i++) begin
      tick();
      pa++;
      if (fs_a) begin
        if ((fs_last < 0 && pa != 0) || (fs_last >= 0 && pa - fs_last != 6400)) fs_bad++;
        fs_last = pa;
        fs_cnt++;
      end
      if (de_a) de_run++;
      if (!de_a && pde) begin
        de_runs++;
        if (de_run != 640) de_bad++;
        de_run = 0;
      end
      if (!hs_a) hs_run++;
      if (!hs_a && phs && (pa % 800) != 656) hs_bad++;
      if (hs_a && !phs) begin
        hs_pulses++;
        if (hs_run != 96) hs_bad++;
        hs_run = 0;
      end
      if (!vs_a && pa < 6400) vs_low++;
      if (!vs_a && pvs && vs_fall < 0) vs_fall = pa;
      if (vs_a && !pvs && vs_rise < 0) vs_rise = pa;
      pde = de_a;
      phs = hs_a;
      pvs = vs_a;
    end
    checks++;
    if (fs_cnt != 2 || fs_bad != 0) begin
      errors++;
      $display("FAIL frame_start: pulses=%0d misplaced=%0d required 2 and 0", fs_cnt, fs_bad);
    end
    checks++;
    if (de_runs != 8 || de_bad != 0) begin
      errors++;
      $display("FAIL de_lines: runs=%0d bad_len=%0d required 8 and 0", de_runs, de_bad);
    end
    checks++;
    if (hs_pulses != 16 || hs_bad != 0) begin
      errors++;
      $display("FAIL hsync: pulses=%0d bad=%0d required 16 and 0", hs_pulses, hs_bad);
    end
    checks++;
    if (vs_low != 1600) begin
      errors++;
      $display("FAIL vsync_len: low=%0d required 1600", vs_low);
    end
    checks++;
    if (vs_fall != 4000 || vs_rise != 5600) begin
      errors++;
      $display("FAIL vsync_edges: fall=%0d rise=%0d required 4000 5600", vs_fall, vs_rise);
    end
    tick();
    pa++;
    checks++;
    if (fs_a !== 1'b1) begin
      errors++;
      $display("FAIL frame_period: fs at 12800=%b required 1", fs_a);
    end
  endtask

  task automatic test_bars();
    int off [7] = '{0, 79, 80, 400, 639, 700, 960};
    logic [23:0] exp [7] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFF0000,
                             24'h000000, 24'h000000, 24'h00FFFF};
    for (int i = 0; i < 7; i++) begin
      run_to(pa, 12800 + off[i]);
      checks++;
      if ({ra, ga, ba} !== exp[i]) begin
        errors++;
        $display("FAIL bars p%0d: got %h required %h", off[i], {ra, ga, ba}, exp[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    run_to(pa, 3 * 6400 + 1899);
    rst_a = 1'b0;
    tick();
    checks++;
    if ({de_a, hs_a, vs_a, fs_a, ra, ga, ba} !== {1'b0, 1'b1, 1'b1, 1'b0, 24'h0}) begin
      errors++;
      $display("FAIL midreset: de/hs/vs/fs/rgb=%b%b%b%b %h required 0110 000000",
               de_a, hs_a, vs_a, fs_a, {ra, ga, ba});
    end
    tick();
    tick();
    checks++;
    if ({de_a, fs_a, ra, ga, ba} !== {1'b0, 1'b0, 24'h0}) begin
      errors++;
      $display("FAIL midreset_hold: de/fs/rgb=%b%b %h required 00 000000", de_a, fs_a, {ra, ga, ba});
    end
    rst_a = 1'b1;
    tick();
    checks++;
    if ({fs_a, de_a, ra, ga, ba} !== {1'b1, 1'b1, 24'hFFFFFF}) begin
      errors++;
      $display("FAIL restart: fs/de/rgb=%b%b %h required 11 ffffff", fs_a, de_a, {ra, ga, ba});
    end
    tick();
    checks++;
    if (fs_a !== 1'b0) begin
      errors++;
      $display("FAIL restart_pulse: fs=%b required 0", fs_a);
    end
  endtask

  task automatic test_mode_change();
    int tp [7] = '{1205, 1242, 2112, 2144, 3648, 3680, 4714};
    logic [23:0] exp [7] = '{24'h123456, 24'h000000, 24'hFFFFFF, 24'h000000,
                             24'h000000, 24'hFFFFFF, 24'hABCDEF};
    mode_b  = 2'd0;
    solid_b = 24'h123456;
    rst_b   = 1'b1;
    pb = -1;
    run_to(pb, 959);
    mode_b  = 2'd2;
    solid_b = 24'hABCDEF;
    for (int i = 0; i < 7; i++) begin
      if (tp[i] > 2200 && pb < 2200) begin
        run_to(pb, 2200);
        mode_b = 2'd0;
      end
      run_to(pb, tp[i]);
      checks++;
      if ({rb, gb, bb} !== exp[i]) begin
        errors++;
        $display("FAIL mode_change p%0d: got %h required %h", tp[i], {rb, gb, bb}, exp[i]);
      end
    end
  endtask

  task automatic test_box();
    localparam logic [23:0] W = 24'hFFFFFF;
    localparam logic [23:0] B = 24'h0000FF;
    int tf [28] = '{5, 5, 5, 5, 5,  6, 6, 6, 6, 6, 6,  7, 7, 7, 7,  8, 8, 8,
                    11, 11, 11,  12, 12,  15, 15, 15,  16, 16};
    int tx [28] = '{6, 5, 6, 10, 9,  7, 6, 7, 11, 10, 10,  8, 7, 8, 11,  7, 7, 11,
                    3, 4, 8,  3, 3,  0, 0, 4,  0, 1};
    int ty [28] = '{5, 6, 6, 6, 9,  4, 5, 5, 5, 8, 9,  3, 4, 4, 7,  2, 3, 3,
                    0, 0, 0,  0, 1,  3, 4, 4,  5, 5};
    logic [23:0] exp [28] = '{B, B, W, B, W,  B, B, W, B, W, B,  B, B, W, W,  B, W, B,
                              B, W, B,  B, W,  B, W, B,  B, W};
    int t;
    mode_c = 2'd0;
    rst_c  = 1'b1;
    pc = -1;
    run_to(pc, 4 * 208 + 50);
    mode_c = 2'd3;
    for (int i = 0; i < 28; i++) begin
      t = tf[i] * 208 + ty[i] * 16 + tx[i];
      run_to(pc, t);
      checks++;
      if ({rc, gc, bc} !== exp[i]) begin
        errors++;
        $display("FAIL box f%0d (%0d,%0d): got %h required %h",
                 tf[i], tx[i], ty[i], {rc, gc, bc}, exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_bars();
    test_reset_midframe();
    test_mode_change();
    test_box();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
